multdiv_iter: RTL and testbench



---
 rtl/multdiv_iter_if.sv | 23 ++
 rtl/multdiv_iter.sv | 169 ++++++++++++++++
 tb/tb_multdiv_iter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_iter_if.sv
// Command/result bundle for the iterative multiply/divide unit.
// The execute stage drives the master side; multdiv_iter implements the slave side.
interface multdiv_iter_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY
   );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 shift-add) and restoring divide, one bit per cycle.
// Define MULTDIV_BOOTH4_EN to run multiply as radix-4 Booth, two bits per cycle.
module multdiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clock,
   input logic          reset,
   multdiv_iter_if.slave md
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_BOOTH4_EN
   localparam int unsigned MUL_ITERS = WIDTH / 2;
`else
   localparam int unsigned MUL_ITERS = WIDTH;
`endif
   localparam int unsigned DIV_ITERS = WIDTH;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W2-1:0]    mcand_q, mcand_d;
   logic [WIDTH:0]   mplier_q, mplier_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic             neg_q, neg_d;
   logic             mul_q, mul_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic             start;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [W2-1:0]    pp;
   logic [W2-1:0]    prod;
   logic [WIDTH-1:0] rem_sh;
   logic [WIDTH:0]   trial;

   assign start = md.ctrl_MULT | md.ctrl_DIV;
   assign mag_a = md.data_operandA[WIDTH-1] ? WIDTH'(0) - md.data_operandA : md.data_operandA;
   assign mag_b = md.data_operandB[WIDTH-1] ? WIDTH'(0) - md.data_operandB : md.data_operandB;

   // Restoring divide: acc holds {remainder, dividend/quotient}, divisor magnitude in mplier.
   assign rem_sh = acc_q[W2-2:WIDTH-1];
   assign trial  = {1'b0, rem_sh} - {1'b0, mplier_q[WIDTH-1:0]};

`ifdef MULTDIV_BOOTH4_EN
   // Booth digit from the overlapping triplet; accumulator is already the signed product.
   always_comb begin
      pp = '0;
      case (mplier_q[2:0])
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = mcand_q << 1;
         3'b100:         pp = W2'(0) - (mcand_q << 1);
         3'b101, 3'b110: pp = W2'(0) - mcand_q;
         default:        pp = '0;
      endcase
   end
   assign prod = acc_q;
`else
   assign pp   = mplier_q[0] ? mcand_q : '0;
   assign prod = neg_q ? W2'(0) - acc_q : acc_q;
`endif

   // Next-state, datapath and output-register logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      mul_d    = mul_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;

      if (start) begin
         cnt_d = '0;
         neg_d = md.data_operandA[WIDTH-1] ^ md.data_operandB[WIDTH-1];
         if (md.ctrl_MULT) begin
            state_d = MUL;
            mul_d   = 1'b1;
            acc_d   = '0;
`ifdef MULTDIV_BOOTH4_EN
            mcand_d  = {{WIDTH{md.data_operandA[WIDTH-1]}}, md.data_operandA};
            mplier_d = {md.data_operandB, 1'b0};
`else
            mcand_d  = {WIDTH'(0), mag_a};
            mplier_d = {1'b0, mag_b};
`endif
         end else begin
            state_d  = DIV;
            mul_d    = 1'b0;
            mcand_d  = '0;
            acc_d    = {WIDTH'(0), mag_a};
            mplier_d = {1'b0, mag_b};
         end
      end else begin
         case (state_q)
            MUL: begin
               acc_d = acc_q + pp;
               cnt_d = cnt_q + CW'(1);
`ifdef MULTDIV_BOOTH4_EN
               mcand_d  = mcand_q << 2;
               mplier_d = {{2{mplier_q[WIDTH]}}, mplier_q[WIDTH:2]};
`else
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
`endif
               if (cnt_q == CW'(MUL_ITERS - 1)) state_d = DONE;
            end
            DIV: begin
               acc_d = {trial[WIDTH] ? rem_sh : trial[WIDTH-1:0], acc_q[WIDTH-2:0], ~trial[WIDTH]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(DIV_ITERS - 1)) state_d = DONE;
            end
            DONE: begin
               rdy_d   = 1'b1;
               state_d = IDLE;
               if (mul_q) begin
                  result_d = prod[WIDTH-1:0];
                  exc_d    = ~((&prod[W2-1:WIDTH-1]) | ~(|prod[W2-1:WIDTH-1]));
               end else if (mplier_q[WIDTH-1:0] == '0) begin
                  result_d = '0;
                  exc_d    = 1'b1;
               end else begin
                  // Only |INT_MIN| / 1 with a positive sign can overflow the quotient.
                  result_d = neg_q ? WIDTH'(0) - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                  exc_d    = ~neg_q & acc_q[WIDTH-1];
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         mul_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         mul_q    <= mul_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
      end
   end

   assign md.data_result    = result_q;
   assign md.data_exception = exc_q;
   assign md.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: directed corner cases plus randomized operands
// against an arithmetic reference model (honours MULTDIV_BOOTH4_EN for multiply latency).
module tb_multdiv_iter;

`ifdef MULTDIV_BOOTH4_EN
   localparam int MUL_LAT = 17;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   multdiv_iter_if #(.WIDTH(32)) bus ();

   multdiv_iter #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .md    (bus)
   );

   always #5 clock = ~clock;

   function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
      longint sa, sb, p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      r  = p[31:0];
      e  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
   endfunction

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
      int q;
      if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         q = $signed(a) / $signed(b);
         r = q;
         e = 1'b0;
      end
   endfunction

   // Issue one command pulse, then scramble operands; report edges-to-RDY and captured outputs.
   task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc,
                        output logic rdy_after);
      @(negedge clock);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      @(posedge clock);
      @(negedge clock);
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      lat = -1;
      res = 'x;
      exc = 1'bx;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY === 1'b1) begin
            lat = n;
            break;
         end
      end
      res = bus.data_result;
      exc = bus.data_exception;
      @(posedge clock);
      #1;
      rdy_after = bus.data_resultRDY;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      repeat (3) @(negedge clock);
      n_checks++;
      if (bus.data_result !== 32'd0) begin
         n_fail++; $display("FAIL reset_result got=%h exp=%h", bus.data_result, 32'd0);
      end
      n_checks++;
      if (bus.data_exception !== 1'b0) begin
         n_fail++; $display("FAIL reset_exc got=%b exp=0", bus.data_exception);
      end
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_checks++;
      if (bus.data_resultRDY !== 1'b0) begin
         n_fail++; $display("FAIL reset_rdy_idle got=%b exp=0", bus.data_resultRDY);
      end
   endtask

   task automatic test_mul_directed();
      logic [31:0] va[4] = '{32'd3, 32'h0001_0000, 32'h8000_0000, 32'd1000};
      logic [31:0] vb[4] = '{32'hFFFF_FFF9, 32'h0001_0000, 32'hFFFF_FFFF, 32'd1000};
      logic [31:0] xr[4] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h000F_4240};
      logic        xe[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int lat; logic [31:0] res; logic exc, ra;
      for (int i = 0; i < 4; i++) begin
         do_op(1'b1, 1'b0, va[i], vb[i], lat, res, exc, ra);
         n_checks++;
         if (res !== xr[i]) begin
            n_fail++; $display("FAIL mul_dir_result[%0d] got=%h exp=%h", i, res, xr[i]);
         end
         n_checks++;
         if (exc !== xe[i]) begin
            n_fail++; $display("FAIL mul_dir_exc[%0d] got=%b exp=%b", i, exc, xe[i]);
         end
         n_checks++;
         if (lat !== MUL_LAT) begin
            n_fail++; $display("FAIL mul_dir_latency[%0d] got=%0d exp=%0d", i, lat, MUL_LAT);
         end
         n_checks++;
         if (ra !== 1'b0) begin
            n_fail++; $display("FAIL mul_dir_rdy_fall[%0d] got=%b exp=0", i, ra);
         end
      end
   endtask

   task automatic test_div_directed();
      logic [31:0] va[4] = '{32'hFFFF_FF9C, 32'd100, 32'd5, 32'h8000_0000};
      logic [31:0] vb[4] = '{32'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] xr[4] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd0, 32'h8000_0000};
      logic        xe[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int lat; logic [31:0] res; logic exc, ra;
      for (int i = 0; i < 4; i++) begin
         do_op(1'b0, 1'b1, va[i], vb[i], lat, res, exc, ra);
         n_checks++;
         if (res !== xr[i]) begin
            n_fail++; $display("FAIL div_dir_result[%0d] got=%h exp=%h", i, res, xr[i]);
         end
         n_checks++;
         if (exc !== xe[i]) begin
            n_fail++; $display("FAIL div_dir_exc[%0d] got=%b exp=%b", i, exc, xe[i]);
         end
         n_checks++;
         if (lat !== DIV_LAT || ra !== 1'b0) begin
            n_fail++; $display("FAIL div_dir_timing[%0d] got lat=%0d fall=%b exp lat=%0d fall=0",
                               i, lat, ra, DIV_LAT);
         end
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] res, er, a, b; logic exc, ee, ra; bit is_mul;
      for (int i = 0; i < 50; i++) begin
         is_mul = (i % 2) == 0;
         a = $signed($urandom) >>> $urandom_range(0, 31);
         b = $signed($urandom) >>> $urandom_range(0, 31);
         if (i % 13 == 5) a = 32'h8000_0000;
         if (is_mul) ref_mul(a, b, er, ee);
         else        ref_div(a, b, er, ee);
         do_op(is_mul, !is_mul, a, b, lat, res, exc, ra);
         n_checks++;
         if (res !== er || exc !== ee) begin
            n_fail++;
            $display("FAIL rand_%s[%0d] a=%h b=%h got=%h/%b exp=%h/%b",
                     is_mul ? "mul" : "div", i, a, b, res, exc, er, ee);
         end
         n_checks++;
         if (lat !== (is_mul ? MUL_LAT : DIV_LAT) || ra !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_timing[%0d] got lat=%0d fall=%b exp lat=%0d fall=0",
                     i, lat, ra, is_mul ? MUL_LAT : DIV_LAT);
         end
      end
   endtask

   task automatic test_restart();
      int early = 0;
      int lat = -1;
      @(negedge clock);
      bus.data_operandA = 32'd6;
      bus.data_operandB = 32'd7;
      bus.ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY !== 1'b0) early++;
      end
      @(negedge clock);
      bus.data_operandA = 32'd84;
      bus.data_operandB = 32'd4;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.ctrl_DIV = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY === 1'b1) begin
            lat = n;
            break;
         end
      end
      n_checks++;
      if (early !== 0) begin
         n_fail++; $display("FAIL restart_early_rdy got=%0d pulses exp=0", early);
      end
      n_checks++;
      if (lat !== DIV_LAT) begin
         n_fail++; $display("FAIL restart_latency got=%0d exp=%0d", lat, DIV_LAT);
      end
      n_checks++;
      if (bus.data_result !== 32'd21 || bus.data_exception !== 1'b0) begin
         n_fail++; $display("FAIL restart_result got=%h/%b exp=%h/0",
                            bus.data_result, bus.data_exception, 32'd21);
      end
   endtask

   task automatic test_hold();
      int lat = -1;
      @(negedge clock);
      bus.data_operandA = 32'd5;
      bus.data_operandB = 32'd5;
      bus.ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (bus.data_result !== 32'd21 || bus.data_exception !== 1'b0) begin
         n_fail++; $display("FAIL hold_while_busy got=%h/%b exp=%h/0",
                            bus.data_result, bus.data_exception, 32'd21);
      end
      for (int n = 4; n <= 100; n++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY === 1'b1) begin
            lat = n;
            break;
         end
      end
      n_checks++;
      if (lat !== MUL_LAT || bus.data_result !== 32'd25) begin
         n_fail++; $display("FAIL hold_next_result got lat=%0d res=%h exp lat=%0d res=%h",
                            lat, bus.data_result, MUL_LAT, 32'd25);
      end
   endtask

   task automatic test_priority();
      int lat; logic [31:0] res; logic exc, ra;
      do_op(1'b1, 1'b1, 32'd2, 32'd3, lat, res, exc, ra);
      n_checks++;
      if (res !== 32'd6 || exc !== 1'b0 || lat !== MUL_LAT) begin
         n_fail++; $display("FAIL priority_mult got=%h/%b lat=%0d exp=%h/0 lat=%0d",
                            res, exc, lat, 32'd6, MUL_LAT);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      int lat; logic [31:0] res; logic exc, ra;
      @(negedge clock);
      bus.data_operandA = 32'd1000;
      bus.data_operandB = 32'd1000;
      bus.ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      repeat (11) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 || bus.data_resultRDY !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_outputs got=%h/%b/%b exp=0/0/0",
                            bus.data_result, bus.data_exception, bus.data_resultRDY);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY !== 1'b0) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++; $display("FAIL reset_mid_no_rdy got=%0d pulses exp=0", pulses);
      end
      do_op(1'b1, 1'b0, 32'd1000, 32'd1000, lat, res, exc, ra);
      n_checks++;
      if (res !== 32'h000F_4240 || exc !== 1'b0 || lat !== MUL_LAT) begin
         n_fail++; $display("FAIL reset_mid_fresh got=%h/%b lat=%0d exp=%h/0 lat=%0d",
                            res, exc, lat, 32'h000F_4240, MUL_LAT);
      end
   endtask

   initial begin
      test_reset();
      test_mul_directed();
      test_div_directed();
      test_random();
      test_restart();
      test_hold();
      test_priority();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
